// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer geometry, line-writer state encoding and the
// latched line-command record. Imported by fb_addr_calc and fb_line_writer.
package fb_pkg;

    localparam int unsigned FB_WIDTH   = 640;
    localparam int unsigned FB_HEIGHT  = 480;
    localparam int unsigned FB_ADDR_W  = 19;
    localparam int unsigned FB_COLOR_W = 4;
    localparam int unsigned FB_X_W     = 10;
    localparam int unsigned FB_Y_W     = 9;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        DRAW,
        FLUSH,
        WAIT_SWAP
    } fb_state_e;

    typedef struct packed {
        logic [FB_X_W-1:0]     x0;
        logic [FB_X_W-1:0]     x1;
        logic [FB_Y_W-1:0]     y0;
        logic [FB_Y_W-1:0]     y1;
        logic [FB_COLOR_W-1:0] color;
    } fb_line_cmd_t;

    function automatic logic [FB_X_W-1:0] abs_diff(input logic [FB_X_W-1:0] a,
                                                   input logic [FB_X_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// fb_addr_calc: linear framebuffer address from (row, col) as row*640 + col,
// built from two shifts and adds. Shared by the write path and the read side.
//   row_i  : pixel row (9 bits)
//   col_i  : pixel column (10 bits)
//   addr_o : 19-bit address, truncated
module fb_addr_calc
    import fb_pkg::*;
(
    input  logic [FB_Y_W-1:0]    row_i,
    input  logic [FB_X_W-1:0]    col_i,
    output logic [FB_ADDR_W-1:0] addr_o
);

    logic [FB_ADDR_W-1:0] row_w;

    assign row_w  = FB_ADDR_W'(row_i);
    assign addr_o = (row_w << 9) + (row_w << 7) + FB_ADDR_W'(col_i);

endmodule

// File: rtl/fb_line_writer.sv
// fb_line_writer: Bresenham line rasteriser writing one pixel per cycle into
// the framebuffer, plus end-of-frame handshake (done pulse, wait for fb_ready).
//   clk, rst            : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (ready only in IDLE)
//   cmd_x0/x1, cmd_y0/y1, cmd_color, cmd_eof : line command / end of frame
//   fb_ready            : buffer-swap-complete pulse (observed in WAIT_SWAP)
//   w_addr, en_w, color_out : registered pixel write port
//   done, busy          : frame-complete pulse, not-idle status
// Build option: FB_LINE_CLIP_EN suppresses en_w for off-screen pixels while
// keeping the one-cycle-per-pixel timing.
module fb_line_writer
    import fb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [FB_X_W-1:0]     cmd_x0,
    input  logic [FB_X_W-1:0]     cmd_x1,
    input  logic [FB_Y_W-1:0]     cmd_y0,
    input  logic [FB_Y_W-1:0]     cmd_y1,
    input  logic [FB_COLOR_W-1:0] cmd_color,
    input  logic                  cmd_eof,
    input  logic                  fb_ready,
    output logic [FB_ADDR_W-1:0]  w_addr,
    output logic                  en_w,
    output logic [FB_COLOR_W-1:0] color_out,
    output logic                  done,
    output logic                  busy
);

    fb_state_e             state_q, state_d;
    fb_line_cmd_t          cmd_q, cmd_d;
    logic [FB_X_W-1:0]     x_q, x_d;
    logic [FB_Y_W-1:0]     y_q, y_d;
    logic signed [11:0]    dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic                  sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic                  last_q, last_d;
    logic                  en_w_q, en_w_d, done_q, done_d;
    logic [FB_ADDR_W-1:0]  w_addr_q, w_addr_d;
    logic [FB_COLOR_W-1:0] color_q, color_d;
    logic [FB_ADDR_W-1:0]  pix_addr;
    logic signed [12:0]    e2, dx13, dy13;

    fb_addr_calc u_addr (
        .row_i  (y_q),
        .col_i  (x_q),
        .addr_o (pix_addr)
    );

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign en_w      = en_w_q;
    assign done      = done_q;
    assign w_addr    = w_addr_q;
    assign color_out = color_q;

    // Bresenham decisions use 2*err of the pre-step error term.
    assign e2   = {err_q, 1'b0};
    assign dx13 = {dx_q[11], dx_q};
    assign dy13 = {dy_q[11], dy_q};

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        x_d      = x_q;
        y_d      = y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        err_d    = err_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        last_d   = last_q;
        en_w_d   = 1'b0;
        done_d   = 1'b0;
        w_addr_d = w_addr_q;
        color_d  = color_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_eof) begin
                        state_d = FLUSH;
                        done_d  = 1'b1;
                    end else begin
                        cmd_d   = '{x0: cmd_x0, x1: cmd_x1, y0: cmd_y0,
                                    y1: cmd_y1, color: cmd_color};
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                x_d      = cmd_q.x0;
                y_d      = cmd_q.y0;
                sx_neg_d = (cmd_q.x1 < cmd_q.x0);
                sy_neg_d = (cmd_q.y1 < cmd_q.y0);
                dx_d     = 12'(abs_diff(cmd_q.x1, cmd_q.x0));
                dy_d     = -12'(abs_diff(FB_X_W'(cmd_q.y1), FB_X_W'(cmd_q.y0)));
                err_d    = dx_d + dy_d;
                last_d   = 1'b0;
                state_d  = DRAW;
            end
            DRAW: begin
                // The final pixel is emitted on the edge that sets last_q; the
                // extra DRAW cycle keeps cmd_ready low while that pixel is out.
                if (last_q) begin
                    state_d = IDLE;
                end else begin
`ifdef FB_LINE_CLIP_EN
                    en_w_d = (x_q < FB_X_W'(FB_WIDTH)) && (y_q < FB_Y_W'(FB_HEIGHT));
`else
                    en_w_d = 1'b1;
`endif
                    w_addr_d = pix_addr;
                    color_d  = cmd_q.color;
                    if ((x_q == cmd_q.x1) && (y_q == cmd_q.y1)) begin
                        last_d = 1'b1;
                    end else begin
                        if (e2 >= dy13) begin
                            err_d = err_d + dy_q;
                            x_d   = sx_neg_q ? (x_q - 1'b1) : (x_q + 1'b1);
                        end
                        if (e2 <= dx13) begin
                            err_d = err_d + dx_q;
                            y_d   = sy_neg_q ? (y_q - 1'b1) : (y_q + 1'b1);
                        end
                    end
                end
            end
            FLUSH:     state_d = WAIT_SWAP;
            WAIT_SWAP: if (fb_ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            last_q   <= 1'b0;
            en_w_q   <= 1'b0;
            done_q   <= 1'b0;
            w_addr_q <= '0;
            color_q  <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            err_q    <= err_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
            last_q   <= last_d;
            en_w_q   <= en_w_d;
            done_q   <= done_d;
            w_addr_q <= w_addr_d;
            color_q  <= color_d;
        end
    end

endmodule

// File: tb/tb_fb_line_writer.sv
// Bench for fb_line_writer: directed line/EOF/reset scenarios; expected pixel
// writes are queued by the stimulus and checked by an independent monitor.
module tb_fb_line_writer;

    logic        clk = 1'b0;
    logic        rst, cmd_valid, cmd_ready, cmd_eof, fb_ready;
    logic [9:0]  cmd_x0, cmd_x1;
    logic [8:0]  cmd_y0, cmd_y1;
    logic [3:0]  cmd_color, color_out;
    logic [18:0] w_addr;
    logic        en_w, done, busy;

    int n_pass = 0;
    int n_total = 0;
    int done_cnt = 0;
    logic [22:0] exp_q[$];
    logic [22:0] mon_e;

    fb_line_writer dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_x1    (cmd_x1),
        .cmd_y0    (cmd_y0),
        .cmd_y1    (cmd_y1),
        .cmd_color (cmd_color),
        .cmd_eof   (cmd_eof),
        .fb_ready  (fb_ready),
        .w_addr    (w_addr),
        .en_w      (en_w),
        .color_out (color_out),
        .done      (done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    endtask

    task automatic push(input int addr, input int col);
        exp_q.push_back({19'(addr), 4'(col)});
    endtask

    // Monitor: every write strobe consumes one scoreboard entry.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (en_w) begin
            chk("en_w_done_exclusive", int'(done), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", int'(w_addr), -1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("w_addr", int'(w_addr), int'(mon_e[22:4]));
                chk("color_out", int'(color_out), int'(mon_e[3:0]));
            end
        end
    end

    task automatic send_line(input int x0, input int y0, input int x1, input int y1,
                             input int col);
        int t = 0;
        while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
        chk("ready_before_cmd", int'(cmd_ready), 1);
        cmd_x0 = 10'(x0); cmd_y0 = 9'(y0); cmd_x1 = 10'(x1); cmd_y1 = 9'(y1);
        cmd_color = 4'(col); cmd_eof = 1'b0; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Called at the negedge right after the accepting edge.
    task automatic measure(input string nm, input int exp_cnt);
        int cnt = 0;
        chk({nm, "_lat_setup"}, int'(en_w), 0);
        @(negedge clk);
        chk({nm, "_lat_draw0"}, int'(en_w), 0);
        @(negedge clk);
        chk({nm, "_first_pixel"}, int'(en_w), 1);
        while (en_w && cnt < 2000) begin
            chk({nm, "_ready_low_while_drawing"}, int'(cmd_ready), 0);
            cnt++;
            @(negedge clk);
        end
        chk({nm, "_pixel_count"}, cnt, exp_cnt);
        chk({nm, "_ready_after_last"}, int'(cmd_ready), 1);
        chk({nm, "_busy_after_last"}, int'(busy), 0);
        chk({nm, "_scoreboard_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        int t, nw, bad;
        rst = 1'b1; cmd_valid = 1'b0; cmd_eof = 1'b0; fb_ready = 1'b0;
        cmd_x0 = '0; cmd_x1 = '0; cmd_y0 = '0; cmd_y1 = '0; cmd_color = '0;
        repeat (2) @(negedge clk);
        chk("rst_en_w", int'(en_w), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_w_addr", int'(w_addr), 0);
        chk("rst_color_out", int'(color_out), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", int'(cmd_ready), 1);

        // Horizontal line, left to right
        push(3210, 4); push(3211, 4); push(3212, 4); push(3213, 4);
        send_line(10, 5, 13, 5, 4'h4);
        measure("horiz", 4);

        // Steep line (0,0)->(2,4)
        push(0, 9); push(641, 9); push(1281, 9); push(1922, 9); push(2562, 9);
        send_line(0, 0, 2, 4, 9);
        measure("steep", 5);

        // Reverse horizontal
        push(3213, 3); push(3212, 3); push(3211, 3); push(3210, 3);
        send_line(13, 5, 10, 5, 3);
        measure("reverse", 4);

        // Degenerate single point
        push(4487, 15);
        send_line(7, 7, 7, 7, 15);
        measure("point", 1);

        // Both directions negative: (5,4)->(3,0)
        push(2565, 2); push(1924, 2); push(1284, 2); push(643, 2); push(3, 2);
        send_line(5, 4, 3, 0, 2);
        measure("negneg", 5);

        // End of frame
        done_cnt = 0;
        cmd_eof = 1'b1; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_eof = 1'b0;
        chk("eof_done_high", int'(done), 1);
        chk("eof_busy", int'(busy), 1);
        chk("eof_ready_low", int'(cmd_ready), 0);
        @(negedge clk);
        chk("eof_done_one_cycle", int'(done), 0);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (cmd_ready || !busy || done) bad++;
        end
        chk("wait_swap_hold_bad_cycles", bad, 0);
        chk("done_pulse_count", done_cnt, 1);
        fb_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fb_ready = 1'b0;
        chk("swap_ready", int'(cmd_ready), 1);
        chk("swap_busy", int'(busy), 0);

        // Stray fb_ready in IDLE
        fb_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fb_ready = 1'b0;
        chk("stray_ready", int'(cmd_ready), 1);
        chk("stray_busy", int'(busy), 0);
        chk("stray_no_done", done_cnt, 1);
        push(641, 1);
        send_line(1, 1, 1, 1, 1);
        measure("after_stray", 1);

        // Right-edge line, clipped or raw depending on build
`ifdef FB_LINE_CLIP_EN
        push(638, 5); push(639, 5);
`else
        push(638, 5); push(639, 5); push(640, 5); push(641, 5);
`endif
        send_line(638, 0, 641, 0, 5);
        t = 0; nw = 0;
        while (!cmd_ready && t < 100) begin
            if (en_w) nw++;
            @(negedge clk);
            t++;
        end
`ifdef FB_LINE_CLIP_EN
        chk("edge_write_count", nw, 2);
`else
        chk("edge_write_count", nw, 4);
`endif
        chk("edge_cycles_to_idle", t, 6);
        chk("edge_scoreboard_empty", exp_q.size(), 0);

        // Reset during the 3rd pixel of an 8-pixel line
        push(6400, 7); push(6401, 7); push(6402, 7);
        send_line(0, 10, 7, 10, 7);
        t = 0;
        while (!en_w && t < 20) begin @(negedge clk); t++; end
        chk("rstline_started", int'(en_w), 1);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        cmd_x0 = 10'd100; cmd_y0 = 9'd100; cmd_x1 = 10'd120; cmd_y1 = 9'd100;
        cmd_valid = 1'b1;
        #1;
        chk("rstline_en_w_now", int'(en_w), 0);
        chk("rstline_w_addr_now", int'(w_addr), 0);
        chk("rstline_busy_now", int'(busy), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cmd_valid = 1'b0;
        chk("rstline_ready_after", int'(cmd_ready), 1);
        repeat (15) @(negedge clk);
        chk("rstline_scoreboard_empty", exp_q.size(), 0);
        chk("rstline_busy_after", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
